// File: rtl/sccb_config_sequencer_if.sv
// SCCB engine bundle: tick/phase, write word and GO out, ACK/END back.
// master = sequencer, slave = write engine.
interface sccb_config_sequencer_if;
  logic        i2c_clk_o;
  logic        i2c_en_o;
  logic [23:0] i2c_data_o;
  logic        i2c_wr_o;
  logic        i2c_go_o;
  logic        i2c_ack_i;
  logic        i2c_end_i;

  modport master (
    output i2c_clk_o,
    output i2c_en_o,
    output i2c_data_o,
    output i2c_wr_o,
    output i2c_go_o,
    input  i2c_ack_i,
    input  i2c_end_i
  );

  modport slave (
    input  i2c_clk_o,
    input  i2c_en_o,
    input  i2c_data_o,
    input  i2c_wr_o,
    input  i2c_go_o,
    output i2c_ack_i,
    output i2c_end_i
  );
endinterface

// File: rtl/sccb_config_sequencer.sv
// Camera register-table sequencer over the single-write SCCB engine.
// Generates the engine tick/SCL phase, retries NACKs, handles ms delays.
module sccb_config_sequencer #(
  parameter int          CLK_DIV      = 500,
  parameter logic [7:0]  LUT_SIZE     = 8'd200,
  parameter logic [7:0]  SLAVE_ID     = 8'h42,
  parameter logic [19:0] PWRUP_CYCLES = 20'd1_000_000,
  parameter logic [16:0] MS_CYCLES    = 17'd100_000,
  parameter int          MAX_RETRY    = 3
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        cfg_start_i,
  output logic [7:0]  lut_index_o,
  input  logic [15:0] lut_data_i,
  sccb_config_sequencer_if.master i2c,
  output logic        cfg_busy_o,
  output logic        cfg_done_o,
  output logic        cfg_error_o,
  output logic [7:0]  err_index_o
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int CW = 25;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] SCL_RISE = DW'(CLK_DIV / 4);
  localparam logic [DW-1:0] SCL_FALL = DW'((3 * CLK_DIV) / 4);
  localparam logic [RW-1:0] RMAX     = RW'(MAX_RETRY);
  localparam logic [CW-1:0] PWR_LAST = CW'(PWRUP_CYCLES) - CW'(1);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_FETCH,
    S_DELAY,
    S_ISSUE,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [23:0]   data_q, data_d;
  logic          ack_q, ack_d;
  logic          gap_q, gap_d;
  logic [7:0]    err_q, err_d;
  logic          go;
  logic          tick;

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_PWRUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      gap_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    data_d  = data_q;
    ack_d   = ack_q;
    gap_d   = gap_q;
    err_d   = err_q;
    go      = 1'b0;
    unique case (state_q)
      S_PWRUP: begin
        if (cnt_q == PWR_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FETCH: begin
        if (idx_q == LUT_SIZE) begin
          state_d = S_DONE;
        end else if (lut_data_i[15:8] == 8'hFF) begin
          cnt_d   = CW'(lut_data_i[7:0]) * CW'(MS_CYCLES);
          state_d = S_DELAY;
        end else begin
          data_d  = {SLAVE_ID, lut_data_i};
          state_d = S_ISSUE;
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          idx_d   = idx_q + 8'd1;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_ISSUE: begin
        go = 1'b1;
        if (i2c.i2c_end_i) begin
          ack_d   = i2c.i2c_ack_i;
          gap_d   = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // two full ticks with GO low let the engine drop END
        if (tick) begin
          if (!gap_q) begin
            gap_d = 1'b1;
          end else if (!ack_q) begin
            retry_d = '0;
            idx_d   = idx_q + 8'd1;
            state_d = S_FETCH;
          end else if (retry_q < RMAX) begin
            retry_d = retry_q + RW'(1);
            state_d = S_FETCH;
          end else begin
            err_d   = idx_q;
            state_d = S_ERROR;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (cfg_start_i) begin
          retry_d = '0;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  assign i2c.i2c_clk_o  = (div_q >= SCL_RISE) && (div_q < SCL_FALL);
  assign i2c.i2c_en_o   = tick;
  assign i2c.i2c_data_o = data_q;
  assign i2c.i2c_wr_o   = 1'b1;
  assign i2c.i2c_go_o   = go;

  assign lut_index_o = idx_q;
  assign cfg_busy_o  = (state_q != S_DONE) && (state_q != S_ERROR);
  assign cfg_done_o  = (state_q == S_DONE);
  assign cfg_error_o = (state_q == S_ERROR);
  assign err_index_o = err_q;

endmodule
